// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_sequencer
// Description : Control-flow sequencer for the 3-stage fetch / decode /
//               execute-write core. Owns the fetch PC and the per-stage
//               enables. It sequences conditional-jump redirects, entry to
//               the external-interrupt trap handler at MTVEC, and MRET
//               return. It also holds the trap CSRs (MEPC, MCAUSE, MIE,
//               MPIE) and the privilege mode.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK              in   1   clock
//   RSTN             in   1   asynchronous active-low reset
//   INTERRUPT        in   1   external interrupt request (level)
//   COND_JUMP_D      in   1   decode stage holds a conditional jump
//   MRET_D           in   1   decode stage holds MRET
//   PC_D             in  32   PC of the instruction in decode
//   JUMP_DEST_E      in  32   resolved jump target (valid in BR_EXEC)
//   PC_OUT           out 32   fetch PC (word index)
//   DECODER_ENABLED  out  1   decode stage enable
//   EXECUTER_ENABLED out  1   execute stage enable (always 1)
//   WRITER_ENABLED   out  1   write-back enable (always 1)
//   CPU_MODE         out  1   0 = user, 1 = machine
//   MEPC             out 32   saved return PC
//   MCAUSE           out 32   trap cause
//   TRAP_TAKEN       out  1   one-cycle pulse on trap entry
// ----------------------------------------------------------------------------
// Build option:
//   IRQ_SYNC_EN  - when defined, INTERRUPT passes through a 2-flop
//                  synchronizer before it sets the pending flag. This adds
//                  2 cycles of detection latency.
// ============================================================================
module pipeline_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter logic [31:0] MTVEC        = 32'd36,
    parameter int          DRAIN_CYCLES = 2        // legal range 1..7
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        INTERRUPT,
    input  logic        COND_JUMP_D,
    input  logic        MRET_D,
    input  logic [31:0] PC_D,
    input  logic [31:0] JUMP_DEST_E,
    output logic [31:0] PC_OUT,
    output logic        DECODER_ENABLED,
    output logic        EXECUTER_ENABLED,
    output logic        WRITER_ENABLED,
    output logic        CPU_MODE,
    output logic [31:0] MEPC,
    output logic [31:0] MCAUSE,
    output logic        TRAP_TAKEN
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0]  ST_RUN        = 3'd0;
    localparam logic [2:0]  ST_BR_EXEC    = 3'd1;
    localparam logic [2:0]  ST_RET_EXEC   = 3'd2;
    localparam logic [2:0]  ST_TRAP_DRAIN = 3'd3;
    localparam logic [2:0]  ST_TRAP_ENTER = 3'd4;
    localparam logic [2:0]  ST_REFILL     = 3'd5;

    // Interrupt bit set, machine external interrupt code 11.
    localparam logic [31:0] CAUSE_MEXT    = 32'h8000_000B;
    localparam logic [2:0]  DRAIN_LOAD    = DRAIN_CYCLES[2:0];

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [31:0] pc;
    logic        cpu_mode;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        mie;
    logic        mpie;
    logic        irq_pend;
    logic [2:0]  drain_cnt;

    // Event qualifiers evaluated in RUN (priority is resolved in next-state)
    logic take_branch;
    logic take_mret;
    logic take_irq;
    logic irq_src;

    // ------------------------------------------------------------------------
    // Interrupt source: optionally synchronised into the CLK domain
    // ------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [1:0] irq_sync;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            irq_sync <= 2'b00;
        end else begin
            irq_sync <= {irq_sync[0], INTERRUPT};
        end
    end

    assign irq_src = irq_sync[1];
`else
    assign irq_src = INTERRUPT;
`endif

    assign take_branch = COND_JUMP_D;
    // MRET in user mode is treated as an ordinary instruction.
    assign take_mret   = MRET_D && cpu_mode;
    // Machine mode runs with MIE cleared, so a request there stays latched
    // until MRET restores MIE and drops back to user mode.
    assign take_irq    = irq_pend && mie && !cpu_mode;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (take_branch) begin
                    state_next = ST_BR_EXEC;
                end else if (take_mret) begin
                    state_next = ST_RET_EXEC;
                end else if (take_irq) begin
                    state_next = ST_TRAP_DRAIN;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_BR_EXEC:    state_next = ST_REFILL;
            ST_RET_EXEC:   state_next = ST_REFILL;
            ST_TRAP_DRAIN: begin
                // The counter holds the number of drain cycles still to go,
                // including the current one.
                if (drain_cnt <= 3'd1) begin
                    state_next = ST_TRAP_ENTER;
                end else begin
                    state_next = ST_TRAP_DRAIN;
                end
            end
            ST_TRAP_ENTER: state_next = ST_REFILL;
            ST_REFILL:     state_next = ST_RUN;
            default:       state_next = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    // Decode runs only in RUN. Every other state is a redirect, a drain or a
    // refill bubble.
    always_comb begin
        DECODER_ENABLED  = 1'b0;
        TRAP_TAKEN       = 1'b0;
        EXECUTER_ENABLED = 1'b1;
        WRITER_ENABLED   = 1'b1;
        case (state)
            ST_RUN:        DECODER_ENABLED = 1'b1;
            ST_TRAP_ENTER: TRAP_TAKEN      = 1'b1;
            default: begin
                DECODER_ENABLED = 1'b0;
                TRAP_TAKEN      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // PC, privilege mode, trap CSRs and drain counter
    // ------------------------------------------------------------------------
    // Redirects load target-1. The following REFILL cycle increments the PC,
    // which lines up with the core's one-word fetch/decode offset. The
    // subtraction wraps modulo 2^32.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc        <= RESET_PC;
            cpu_mode  <= 1'b0;
            mepc      <= 32'd0;
            mcause    <= 32'd0;
            mie       <= 1'b1;
            mpie      <= 1'b0;
            drain_cnt <= 3'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (state_next == ST_RUN) begin
                        pc <= pc + 32'd1;
                    end
                    if (state_next == ST_TRAP_DRAIN) begin
                        mepc      <= PC_D;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_BR_EXEC: begin
                    pc <= JUMP_DEST_E - 32'd1;
                end
                ST_RET_EXEC: begin
                    pc       <= mepc - 32'd1;
                    cpu_mode <= 1'b0;
                    mie      <= mpie;
                end
                ST_TRAP_DRAIN: begin
                    drain_cnt <= drain_cnt - 3'd1;
                end
                ST_TRAP_ENTER: begin
                    pc       <= MTVEC - 32'd1;
                    cpu_mode <= 1'b1;
                    mcause   <= CAUSE_MEXT;
                    mpie     <= mie;
                    mie      <= 1'b0;
                end
                ST_REFILL: begin
                    pc <= pc + 32'd1;
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pending interrupt latch
    // ------------------------------------------------------------------------
    // Sticky from any sampled request until the trap is actually entered, so
    // requests arriving during a branch, an MRET or machine mode survive.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            irq_pend <= 1'b0;
        end else if (state == ST_TRAP_ENTER) begin
            irq_pend <= 1'b0;
        end else if (irq_src) begin
            irq_pend <= 1'b1;
        end
    end

    assign PC_OUT   = pc;
    assign CPU_MODE = cpu_mode;
    assign MEPC     = mepc;
    assign MCAUSE   = mcause;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_sequencer
// Description : Directed, table-driven self-checking bench for
//               pipeline_sequencer in the default build (IRQ_SYNC_EN not
//               defined). It also has a hand-written sequence for a reset
//               that arrives in the middle of a trap drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;

    localparam logic [31:0] MC = 32'h8000_000B;

    logic        clk;
    logic        rst_n;
    logic        interrupt;
    logic        cond_jump_d;
    logic        mret_d;
    logic [31:0] pc_d;
    logic [31:0] jump_dest_e;
    logic [31:0] pc_out;
    logic        decoder_enabled;
    logic        executer_enabled;
    logic        writer_enabled;
    logic        cpu_mode;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        trap_taken;

    pipeline_sequencer #(
        .RESET_PC     (32'd0),
        .MTVEC        (32'd36),
        .DRAIN_CYCLES (2)
    ) dut (
        .CLK              (clk),
        .RSTN             (rst_n),
        .INTERRUPT        (interrupt),
        .COND_JUMP_D      (cond_jump_d),
        .MRET_D           (mret_d),
        .PC_D             (pc_d),
        .JUMP_DEST_E      (jump_dest_e),
        .PC_OUT           (pc_out),
        .DECODER_ENABLED  (decoder_enabled),
        .EXECUTER_ENABLED (executer_enabled),
        .WRITER_ENABLED   (writer_enabled),
        .CPU_MODE         (cpu_mode),
        .MEPC             (mepc),
        .MCAUSE           (mcause),
        .TRAP_TAKEN       (trap_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each record holds the inputs that are driven before a rising edge and
    // the outputs that are expected just after that edge.
    typedef struct {
        logic        rst_n;
        logic        irq;
        logic        cj;
        logic        mret;
        logic [31:0] pcd;
        logic [31:0] jd;
        logic [31:0] e_pc;
        logic        e_dec;
        logic        e_mode;
        logic [31:0] e_mepc;
        logic [31:0] e_mcause;
        logic        e_trap;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;
    int   trap_pulses = 0;

    task automatic v(input logic r, input logic irq, input logic cj, input logic mr,
                     input logic [31:0] pcd, input logic [31:0] jd,
                     input logic [31:0] epc, input logic edec, input logic emode,
                     input logic [31:0] emepc, input logic [31:0] emc, input logic etrap);
        vec_t t;
        t = '{r, irq, cj, mr, pcd, jd, epc, edec, emode, emepc, emc, etrap};
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (trap_taken === 1'b1) trap_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        interrupt   = 1'b0;
        cond_jump_d = 1'b0;
        mret_d      = 1'b0;
        pc_d        = 32'd0;
        jump_dest_e = 32'd0;

        // Reset held for 3 cycles.
        repeat (3) v(0,0,0,0, 0,0,  0,1,0, 0,0,0);
        // Free-running count up to PC 10.
        for (int p = 1; p <= 10; p++) v(1,0,0,0, 0,0, p,1,0, 0,0,0);
        // Conditional jump at PC 10 to 30: 10, 29, 30, 31 with decode off for 2 cycles.
        v(1,0,1,0, 0,30, 10,0,0, 0,0,0);
        v(1,0,0,0, 0,30, 29,0,0, 0,0,0);
        v(1,0,0,0, 0,0,  30,1,0, 0,0,0);
        v(1,0,0,0, 0,0,  31,1,0, 0,0,0);
        // User-mode interrupt pulse, PC_D=7 in the detecting cycle.
        v(1,1,0,0, 0,0,  32,1,0, 0,0,0);
        v(1,0,0,0, 7,0,  32,0,0, 7,0,0);
        v(1,0,0,0, 7,0,  32,0,0, 7,0,0);
        v(1,0,0,0, 7,0,  32,0,0, 7,0,1);
        v(1,0,0,0, 0,0,  35,0,1, 7,MC,0);
        v(1,0,0,0, 0,0,  36,1,1, 7,MC,0);
        // Jump target 0 wraps to 0xFFFFFFFF before refilling to 0.
        v(1,0,1,0, 0,0,  36,0,1, 7,MC,0);
        v(1,0,0,0, 0,0,  32'hFFFF_FFFF,0,1, 7,MC,0);
        v(1,0,0,0, 0,0,  0,1,1, 7,MC,0);
        v(1,0,0,0, 0,0,  1,1,1, 7,MC,0);
        // Interrupt in machine mode is latched but not taken.
        v(1,1,0,0, 0,0,  2,1,1, 7,MC,0);
        v(1,0,0,0, 0,0,  3,1,1, 7,MC,0);
        // MRET to MEPC=7: 6 then 7, user mode.
        v(1,0,0,1, 0,0,  3,0,1, 7,MC,0);
        v(1,0,0,0, 0,0,  6,0,0, 7,MC,0);
        v(1,0,0,0, 0,0,  7,1,0, 7,MC,0);
        // Pending request is taken right after refill.
        v(1,0,0,0, 20,0, 7,0,0, 20,MC,0);
        v(1,0,0,0, 20,0, 7,0,0, 20,MC,0);
        v(1,0,0,0, 20,0, 7,0,0, 20,MC,1);
        v(1,0,0,0, 0,0,  35,0,1, 20,MC,0);
        v(1,0,0,0, 0,0,  36,1,1, 20,MC,0);
        // Return to 20.
        v(1,0,0,1, 0,0,  36,0,1, 20,MC,0);
        v(1,0,0,0, 0,0,  19,0,0, 20,MC,0);
        v(1,0,0,0, 0,0,  20,1,0, 20,MC,0);
        // MRET in user mode is an ordinary instruction.
        v(1,0,0,1, 0,0,  21,1,0, 20,MC,0);
        // Branch and interrupt together: branch first, then trap with MEPC=30.
        v(1,1,1,0, 0,30, 21,0,0, 20,MC,0);
        v(1,0,0,0, 0,30, 29,0,0, 20,MC,0);
        v(1,0,0,0, 30,0, 30,1,0, 20,MC,0);
        v(1,0,0,0, 30,0, 30,0,0, 30,MC,0);
        v(1,0,0,0, 30,0, 30,0,0, 30,MC,0);
        v(1,0,0,0, 30,0, 30,0,0, 30,MC,1);
        v(1,0,0,0, 0,0,  35,0,1, 30,MC,0);
        v(1,0,0,0, 0,0,  36,1,1, 30,MC,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n       = vecs[i].rst_n;
            interrupt   = vecs[i].irq;
            cond_jump_d = vecs[i].cj;
            mret_d      = vecs[i].mret;
            pc_d        = vecs[i].pcd;
            jump_dest_e = vecs[i].jd;
            @(posedge clk);
            #1;
            check($sformatf("v%0d pc", i),     pc_out,          vecs[i].e_pc);
            check($sformatf("v%0d dec", i),    32'(decoder_enabled), 32'(vecs[i].e_dec));
            check($sformatf("v%0d mode", i),   32'(cpu_mode),   32'(vecs[i].e_mode));
            check($sformatf("v%0d mepc", i),   mepc,            vecs[i].e_mepc);
            check($sformatf("v%0d mcause", i), mcause,          vecs[i].e_mcause);
            check($sformatf("v%0d trap", i),   32'(trap_taken), 32'(vecs[i].e_trap));
            check($sformatf("v%0d exe_wr", i), {30'd0, executer_enabled, writer_enabled}, 32'd3);
        end

        // Reset arriving mid-drain.
        @(negedge clk);
        rst_n       = 1'b0;
        interrupt   = 1'b0;
        cond_jump_d = 1'b0;
        mret_d      = 1'b0;
        pc_d        = 32'd0;
        jump_dest_e = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid pc_before_irq", pc_out, 32'd2);
        @(negedge clk);
        interrupt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        interrupt = 1'b0;
        pc_d      = 32'd9;
        @(posedge clk);
        #1;
        check("mid in_drain_dec", 32'(decoder_enabled), 32'd0);
        check("mid in_drain_mepc", mepc, 32'd9);
        trap_pulses = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid async_pc", pc_out, 32'd0);
        check("mid async_mepc", mepc, 32'd0);
        check("mid async_dec", 32'(decoder_enabled), 32'd1);
        check("mid async_trap", 32'(trap_taken), 32'd0);
        check("mid async_mode", 32'(cpu_mode), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("mid after_pc", pc_out, 32'd6);
        check("mid after_dec", 32'(decoder_enabled), 32'd1);
        check("mid after_mcause", mcause, 32'd0);
        @(negedge clk);
        check("mid trap_pulses", 32'(trap_pulses), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central control-flow sequencer for the 3-stage fetch/decode/execute-write core.
- Owns the fetch PC and drives the per-stage enables; the core no longer carries ad-hoc stall counters.
- Sequences conditional-jump redirects, external-interrupt trap entry to MTVEC, and MRET return.
- Holds the trap CSRs MEPC, MCAUSE, MIE and MPIE, and the privilege mode.

Parameters:
- RESET_PC, 0, PC_OUT value after reset (word index).
- MTVEC, 36, trap handler entry (word index).
- DRAIN_CYCLES, 2, cycles spent letting in-flight execute/write instructions retire before trap redirect; legal range 1..7.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset, asynchronous, active-low.
- INTERRUPT  in  1  external interrupt request, level.
- COND_JUMP_D  in  1  decode stage holds a conditional jump.
- MRET_D  in  1  decode stage holds MRET.
- PC_D  in  32  PC of the instruction in decode.
- JUMP_DEST_E  in  32  resolved jump target from execute; valid in BR_EXEC.
- PC_OUT  out  32  fetch PC.
- DECODER_ENABLED  out  1  decode stage enable.
- EXECUTER_ENABLED  out  1  execute stage enable.
- WRITER_ENABLED  out  1  write-back enable.
- CPU_MODE  out  1  privilege mode: 0 = user, 1 = machine.
- MEPC  out  32  saved return PC.
- MCAUSE  out  32  trap cause.
- TRAP_TAKEN  out  1  one-cycle pulse on trap entry.

Behaviour:
- Reset, asynchronous while RSTN=0:
  - PC_OUT=RESET_PC; DECODER_ENABLED, EXECUTER_ENABLED, WRITER_ENABLED = 1.
  - CPU_MODE=0, MEPC=0, MCAUSE=0, TRAP_TAKEN=0.
  - Internal: MIE=1, MPIE=0, irq_pend=0, state=RUN.
- A reset arriving mid-sequence aborts it; nothing is retained.
- irq_pend: set on any cycle INTERRUPT=1; cleared only in TRAP_ENTER.
- Redirect convention: every redirect loads target-1, then the following cycle increments, which matches the core's fetch/decode offset.
- FSM states:
  - RUN: default PC_OUT+=1. Priority order:
    1. COND_JUMP_D: PC_OUT holds, DECODER_ENABLED=0, go to BR_EXEC.
    2. MRET_D and CPU_MODE=1: PC_OUT holds, DECODER_ENABLED=0, go to RET_EXEC.
    3. irq_pend and MIE and CPU_MODE=0: PC_OUT holds, DECODER_ENABLED=0, MEPC<=PC_D, load drain counter with DRAIN_CYCLES, go to TRAP_DRAIN.
  - BR_EXEC: PC_OUT<=JUMP_DEST_E-1; go to REFILL.
  - RET_EXEC: PC_OUT<=MEPC-1; CPU_MODE<=0; MIE<=MPIE; go to REFILL.
  - TRAP_DRAIN: PC_OUT holds, decode disabled, execute/write enabled. Counter decrements each cycle; on reaching 1, go to TRAP_ENTER.
  - TRAP_ENTER:
    - PC_OUT<=MTVEC-1; CPU_MODE<=1.
    - MCAUSE<=32'h8000000B; MPIE<=MIE; MIE<=0.
    - irq_pend<=0; TRAP_TAKEN=1 for this cycle only.
    - Go to REFILL.
  - REFILL: DECODER_ENABLED<=1; PC_OUT+=1; go to RUN.
- Simultaneous events and boundaries:
  - Interrupt during a branch or MRET sequence stays pending and is evaluated on the RUN cycle after REFILL. MEPC therefore captures the redirect target.
  - Interrupt in machine mode is ignored (MIE=0) but stays latched; it is taken right after MRET completes.
  - MRET_D in user mode is ignored: treated as a normal instruction, no state change.
  - COND_JUMP_D and MRET_D outside RUN are ignored; decode is disabled in those states.
- Arithmetic: PC arithmetic is 32-bit unsigned modulo 2^32. MTVEC-1 and target-1 wrap silently when the value is 0.
- EXECUTER_ENABLED and WRITER_ENABLED are 1 in every state; they are kept as ports for future flush support.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: INTERRUPT passes through a 2-flop synchronizer reset to 0 before setting irq_pend. Trap detection latency grows by 2 cycles.
- Undefined: INTERRUPT is sampled directly; irq_pend sets the cycle after INTERRUPT is high.

Test Plan:
- Reset: hold RSTN=0 for 3 cycles, then release -> PC_OUT=0, all enables 1, CPU_MODE=0, MEPC=0, MCAUSE=0, TRAP_TAKEN=0; PC_OUT=1,2,3 on the next clocks.
- Branch: at PC_OUT=10 assert COND_JUMP_D one cycle, JUMP_DEST_E=30 -> PC_OUT sequence 10, 29, 30, 31; DECODER_ENABLED=0 for exactly 2 cycles.
- Interrupt, user mode, no macro: 1-cycle INTERRUPT pulse, PC_D=7 on the detecting RUN cycle -> 2 drain cycles, then MEPC=7, MCAUSE=32'h8000000B, PC_OUT=35 then 36, CPU_MODE=1, TRAP_TAKEN high exactly 1 cycle.
- Branch + interrupt same cycle, JUMP_DEST_E=30 -> branch completes first; trap follows with MEPC=30.
- MRET with MEPC=7, plus INTERRUPT asserted during the handler -> PC_OUT 6 then 7, CPU_MODE=0, MIE=1; a second trap is taken immediately after REFILL.
- Reset mid-TRAP_DRAIN -> all outputs return to reset values; no TRAP_TAKEN pulse; irq_pend cleared.
